// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the buffered UART transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
    localparam int UART_FIFO_DEPTH_DEFAULT   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO for the UART transmitter: push/pop, full/empty/count,
// writes on full are dropped and flagged with a one-cycle overflow pulse.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [UART_DATA_BITS-1:0] push_data_i,
    input  logic                      pop_i,
    output logic [UART_DATA_BITS-1:0] pop_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]             wr_ptr_q;
    logic [PW-1:0]             rd_ptr_q;
    logic [CW-1:0]             count_q;
    logic [CW-1:0]             count_d;
    logic                      overflow_q;
    logic                      do_push;
    logic                      do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Full is taken from the registered count, so a same-cycle pop never frees room for a write.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is deliberately not reset; pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_i && full_o;
            count_q    <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer (LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop (8E1).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] i_data,
    input  logic                      i_enable,
    output logic                      o_tx,
    output logic                      o_busy,
    output logic                      o_full,
    output logic                      o_overflow
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_e               state_q;
    logic                      tx_q;
    logic [BW-1:0]             baud_q;
    logic [2:0]                bit_q;
    logic [UART_DATA_BITS-1:0] shift_q;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    logic                          fifo_empty;
    logic                          fifo_full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [UART_DATA_BITS-1:0]     fifo_data;
    logic                          pop;
    logic                          baud_done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (i_enable),
        .push_data_i (i_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .overflow_o  (o_overflow)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    // Pop only when a new frame starts: from IDLE, or at the last stop cycle for back-to-back frames.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            pop = (state_q == ST_IDLE) || (state_q == ST_STOP && baud_done);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tx_q     <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q  <= fifo_data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^fifo_data;
`endif
                        tx_q     <= 1'b0;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q  <= fifo_data;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^fifo_data;
`endif
                            tx_q     <= 1'b0;
                            state_q  <= ST_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx   = tx_q;
    assign o_full = fifo_full;
    assign o_busy = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame-level reference model, a line
// decoder, and directed vectors with hand-computed expectations.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       i_enable = 1'b0;
    logic [7:0] i_data   = 8'h00;
    logic       o_tx;
    logic       o_busy;
    logic       o_full;
    logic       o_overflow;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_data     (i_data),
        .i_enable   (i_enable),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the frame currently on the line as a bit list.
    logic [7:0]  mq[$];
    bit          m_active = 1'b0;
    logic [10:0] m_bits   = '1;
    int          m_cyc    = 0;
    bit          m_ovf    = 1'b0;
    bit          m_full_before;
    bit          m_pop;
    logic [7:0]  m_byte;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_cyc    = 0;
            m_ovf    = 1'b0;
        end else begin
            m_full_before = (mq.size() == DEPTH);
            m_pop = 1'b0;
            if (!m_active) begin
                m_pop = (mq.size() != 0);
            end else if (m_cyc == FRAME - 1) begin
                m_active = 1'b0;
                m_pop    = (mq.size() != 0);
            end else begin
                m_cyc++;
            end
            if (m_pop) begin
                m_byte      = mq.pop_front();
                m_bits      = '1;
                m_bits[0]   = 1'b0;
                m_bits[8:1] = m_byte;
`ifdef UART_TX_PARITY_EN
                m_bits[9]   = ^m_byte;
`endif
                m_active    = 1'b1;
                m_cyc       = 0;
            end
            m_ovf = i_enable && m_full_before;
            if (i_enable && !m_full_before) mq.push_back(i_data);
        end
    end

    function automatic logic exp_tx();
        if (!m_active) return 1'b1;
        return m_bits[4'(m_cyc / CPB)];
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("tx", 32'(o_tx), 32'(exp_tx()));
            check("busy", 32'(o_busy), 32'(m_active || (mq.size() != 0)));
            check("full", 32'(o_full), 32'(mq.size() == DEPTH));
            check("overflow", 32'(o_overflow), 32'(m_ovf));
        end
    end

    // Line decoder: samples each bit in its middle, collects received bytes.
    bit         rx_busy = 1'b0;
    int         rx_t    = 0;
    int         rx_k;
    logic [7:0] rx_sh   = '0;
    logic [7:0] rx_q[$];
    int         ovf_cnt = 0;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            rx_busy = 1'b0;
            rx_t    = 0;
        end else begin
            if (o_overflow === 1'b1) ovf_cnt++;
            if (!rx_busy) begin
                if (o_tx === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_t    = 0;
                end
            end else begin
                rx_t++;
                if (rx_t % CPB == CPB / 2) begin
                    rx_k = rx_t / CPB;
                    if (rx_k >= 1 && rx_k <= 8) begin
                        rx_sh[rx_k-1] = o_tx;
                    end else if (rx_k == NB - 1) begin
                        rx_q.push_back(rx_sh);
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        i_data   = d;
        i_enable = 1'b1;
        @(posedge clk);
        #2;
        i_enable = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < budget), 32'd1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    logic w_tx   [FRAME];
    logic w_busy [FRAME];
    int   a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int   ov0;

    task automatic capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            w_tx[i]   = o_tx;
            w_busy[i] = o_busy;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_tx", 32'(o_tx), 32'd1);
        check("idle_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #2;

        // Single byte A5: start bit one cycle after capture, LSB first
        rx_q.delete();
        send(8'hA5);
        @(negedge clk);
        check("a5_pre_tx", 32'(o_tx), 32'd1);
        check("a5_pre_busy", 32'(o_busy), 32'd1);
        capture_frame();
        @(negedge clk);
        check("a5_busy_end", 32'(o_busy), 32'd0);
        check("a5_start_first", 32'(w_tx[0]), 32'd0);
        check("a5_start_last", 32'(w_tx[CPB-1]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("a5_bit%0d", k), 32'(w_tx[CPB*(k+1) + CPB/2]), 32'(a5_bits[k]));
        end
`ifdef UART_TX_PARITY_EN
        check("a5_parity", 32'(w_tx[9*CPB + CPB/2]), 32'd0);
`endif
        check("a5_stop", 32'(w_tx[(NB-1)*CPB + CPB/2]), 32'd1);
        check("a5_busy_last", 32'(w_busy[FRAME-1]), 32'd1);
        @(posedge clk);
        #2;
        check("a5_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) check("a5_rx_byte", 32'(rx_q[0]), 32'h0000_00A5);

        // Splitter burst: two back-to-back frames
        rx_q.delete();
        send(8'h12);
        send(8'h34);
        wait_idle(1000);
        check("burst_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("burst_rx0", 32'(rx_q[0]), 32'h12);
            check("burst_rx1", 32'(rx_q[1]), 32'h34);
        end

        // Five writes from IDLE all fit; a sixth while full is dropped
        rx_q.delete();
        ov0 = ovf_cnt;
        for (int i = 1; i <= 5; i++) send(8'(i));
        @(negedge clk);
        check("ovf1_full", 32'(o_full), 32'd1);
        check("ovf1_no_pulse", 32'(o_overflow), 32'd0);
        @(posedge clk);
        #2;
        send(8'h06);
        @(negedge clk);
        check("ovf1_pulse", 32'(o_overflow), 32'd1);
        @(negedge clk);
        check("ovf1_pulse_end", 32'(o_overflow), 32'd0);
        @(posedge clk);
        #2;
        wait_idle(2000);
        check("ovf1_pulse_count", 32'(ovf_cnt - ov0), 32'd1);
        check("ovf1_rx_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check($sformatf("ovf1_rx%0d", i), 32'(rx_q[i]), 32'(i + 1));
        end

        // Frame in progress, FIFO filled by four writes, fifth dropped
        rx_q.delete();
        ov0 = ovf_cnt;
        send(8'h10);
        repeat (6) @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) send(8'(8'h21 + i));
        @(negedge clk);
        check("ovf2_pulse", 32'(o_overflow), 32'd1);
        @(posedge clk);
        #2;
        wait_idle(2000);
        check("ovf2_pulse_count", 32'(ovf_cnt - ov0), 32'd1);
        check("ovf2_rx_count", 32'(rx_q.size()), 32'd5);
        if (rx_q.size() == 5) begin
            check("ovf2_rx0", 32'(rx_q[0]), 32'h10);
            check("ovf2_rx1", 32'(rx_q[1]), 32'h21);
            check("ovf2_rx4", 32'(rx_q[4]), 32'h24);
        end

        // Reset during DATA bit 3 of C3 (a 0 bit) with two bytes still queued
        rx_q.delete();
        send(8'hC3);
        send(8'h3C);
        send(8'h81);
        repeat (16) @(posedge clk);
        #2;
        check("mid_bit3_tx", 32'(o_tx), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_async_tx", 32'(o_tx), 32'd1);
        check("mid_async_busy", 32'(o_busy), 32'd0);
        check("mid_async_full", 32'(o_full), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_after_busy", 32'(o_busy), 32'd0);
        check("mid_after_tx", 32'(o_tx), 32'd1);
        check("mid_after_rx", 32'(rx_q.size()), 32'd0);
        @(posedge clk);
        #2;

`ifdef UART_TX_PARITY_EN
        // 8'h07 has three ones: even parity bit is 1, frame is 44 cycles
        rx_q.delete();
        send(8'h07);
        @(negedge clk);
        capture_frame();
        @(negedge clk);
        check("par07_bit", 32'(w_tx[9*CPB + CPB/2]), 32'd1);
        check("par07_busy_last", 32'(w_busy[FRAME-1]), 32'd1);
        check("par07_busy_end", 32'(o_busy), 32'd0);
        @(posedge clk);
        #2;
        check("par07_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) check("par07_rx_byte", 32'(rx_q[0]), 32'h07);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
